// File: rtl/billiard_pkg.sv
// rtl/billiard_pkg.sv - shared launcher types, angle limit and 91-entry sine table
package billiard_pkg;

    localparam int LAUNCH_VEL_W = 11;

    typedef logic signed [LAUNCH_VEL_W-1:0] vel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_SCALE,
        ST_OFFER,
        ST_COOLDOWN
    } launcher_state_e;

    localparam logic [9:0] ANGLE_MAX = 10'd359;

    // round(256*sin(k deg)), k = 0..90
    localparam logic [8:0] SIN_TABLE [0:90] = '{
        9'd0,   9'd4,   9'd9,   9'd13,  9'd18,  9'd22,  9'd27,  9'd31,  9'd36,  9'd40,
        9'd44,  9'd49,  9'd53,  9'd58,  9'd62,  9'd66,  9'd71,  9'd75,  9'd79,  9'd83,
        9'd88,  9'd92,  9'd96,  9'd100, 9'd104, 9'd108, 9'd112, 9'd116, 9'd120, 9'd124,
        9'd128, 9'd132, 9'd136, 9'd139, 9'd143, 9'd147, 9'd150, 9'd154, 9'd158, 9'd161,
        9'd165, 9'd168, 9'd171, 9'd175, 9'd178, 9'd181, 9'd184, 9'd187, 9'd190, 9'd193,
        9'd196, 9'd199, 9'd202, 9'd204, 9'd207, 9'd210, 9'd212, 9'd215, 9'd217, 9'd219,
        9'd222, 9'd224, 9'd226, 9'd228, 9'd230, 9'd232, 9'd234, 9'd236, 9'd237, 9'd239,
        9'd241, 9'd242, 9'd243, 9'd245, 9'd246, 9'd247, 9'd248, 9'd249, 9'd250, 9'd251,
        9'd252, 9'd253, 9'd254, 9'd254, 9'd255, 9'd255, 9'd255, 9'd256, 9'd256, 9'd256,
        9'd256
    };

endpackage

// File: rtl/trig_quadrant_lut.sv
// rtl/trig_quadrant_lut.sv - quadrant fold of a 0..359 degree angle onto the sine table
module trig_quadrant_lut
    import billiard_pkg::*;
(
    input  logic [9:0] angle,
    output logic [8:0] sin_mag,
    output logic [8:0] cos_mag,
    output logic       sin_neg,
    output logic       cos_neg
);

    logic [6:0] b;
    logic [6:0] s_idx;
    logic [6:0] c_idx;

    always_comb begin
        b       = '0;
        s_idx   = '0;
        c_idx   = '0;
        sin_neg = 1'b0;
        cos_neg = 1'b0;
        if (angle < 10'd90) begin
            b     = 7'(angle);
            s_idx = b;
            c_idx = 7'd90 - b;
        end else if (angle < 10'd180) begin
            b       = 7'(angle - 10'd90);
            s_idx   = 7'd90 - b;
            c_idx   = b;
            cos_neg = 1'b1;
        end else if (angle < 10'd270) begin
            b       = 7'(angle - 10'd180);
            s_idx   = b;
            c_idx   = 7'd90 - b;
            sin_neg = 1'b1;
            cos_neg = 1'b1;
        end else begin
            b       = 7'(angle - 10'd270);
            s_idx   = 7'd90 - b;
            c_idx   = b;
            sin_neg = 1'b1;
        end
        sin_mag = SIN_TABLE[s_idx];
        cos_mag = SIN_TABLE[c_idx];
    end

endmodule

// File: rtl/cue_launcher.sv
// rtl/cue_launcher.sv - strike/angle/power to cue-ball velocity offer; CUE_LAUNCHER_SHOT_COUNT_EN enables shot_count
module cue_launcher
    import billiard_pkg::*;
#(
    parameter int MIN_SPEED       = 16,
    parameter int SPEED_STEP      = 4,
    parameter int POWER_MAX       = 100,
    parameter int COOLDOWN_FRAMES = 2,
    parameter int VEL_W           = 11
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    strike,
    input  logic [9:0]              angle,
    input  logic [7:0]              power,
    input  logic                    vel_ready,
    output logic                    vel_valid,
    output logic signed [VEL_W-1:0] velX,
    output logic signed [VEL_W-1:0] velY,
    output logic                    busy,
    output logic                    angle_err,
    output logic [7:0]              shot_count
);

    localparam logic [7:0] POWER_CAP = 8'(POWER_MAX);
    localparam logic [7:0] COOL_INIT = 8'(COOLDOWN_FRAMES);

    launcher_state_e state_q, state_d;
    logic [9:0]       angle_q, angle_d;
    logic [7:0]       power_q, power_d;
    logic [8:0]       sin_mag_q, sin_mag_d, cos_mag_q, cos_mag_d;
    logic             sin_neg_q, sin_neg_d, cos_neg_q, cos_neg_d;
    logic [VEL_W-1:0] velx_q, velx_d, vely_q, vely_d;
    logic             vel_valid_q, vel_valid_d;
    logic             angle_err_q, angle_err_d;
    logic [7:0]       cool_q, cool_d;

    logic [8:0]       lut_sin_mag, lut_cos_mag;
    logic             lut_sin_neg, lut_cos_neg;
    logic [15:0]      speed;
    logic [24:0]      prod_x, prod_y;
    logic [VEL_W-1:0] mag_x, mag_y;
    logic             handshake;

    trig_quadrant_lut u_lut (
        .angle   (angle_q),
        .sin_mag (lut_sin_mag),
        .cos_mag (lut_cos_mag),
        .sin_neg (lut_sin_neg),
        .cos_neg (lut_cos_neg)
    );

    // Magnitudes are scaled unsigned and the sign applied afterwards, so quadrants mirror exactly
    always_comb begin
        speed  = 16'(MIN_SPEED) + 16'(power_q) * 16'(SPEED_STEP);
        prod_x = 25'(speed) * 25'(cos_mag_q);
        prod_y = 25'(speed) * 25'(sin_mag_q);
        mag_x  = VEL_W'(prod_x >> 8);
        mag_y  = VEL_W'(prod_y >> 8);
    end

    assign handshake = (state_q == ST_OFFER) && vel_valid_q && vel_ready;

    always_comb begin
        state_d     = state_q;
        angle_d     = angle_q;
        power_d     = power_q;
        sin_mag_d   = sin_mag_q;
        cos_mag_d   = cos_mag_q;
        sin_neg_d   = sin_neg_q;
        cos_neg_d   = cos_neg_q;
        velx_d      = velx_q;
        vely_d      = vely_q;
        vel_valid_d = vel_valid_q;
        angle_err_d = 1'b0;
        cool_d      = cool_q;
        case (state_q)
            ST_IDLE: begin
                if (strike) begin
                    if (angle <= ANGLE_MAX) begin
                        angle_d = angle;
                        power_d = (power > POWER_CAP) ? POWER_CAP : power;
                        state_d = ST_LOOKUP;
                    end else begin
                        angle_err_d = 1'b1;
                    end
                end
            end
            ST_LOOKUP: begin
                sin_mag_d = lut_sin_mag;
                cos_mag_d = lut_cos_mag;
                sin_neg_d = lut_sin_neg;
                cos_neg_d = lut_cos_neg;
                state_d   = ST_SCALE;
            end
            ST_SCALE: begin
                velx_d      = cos_neg_q ? ('0 - mag_x) : mag_x;
                vely_d      = sin_neg_q ? ('0 - mag_y) : mag_y;
                vel_valid_d = 1'b1;
                state_d     = ST_OFFER;
            end
            ST_OFFER: begin
                if (handshake) begin
                    vel_valid_d = 1'b0;
                    cool_d      = COOL_INIT;
                    state_d     = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                if (cool_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else if (startOfFrame) begin
                    cool_d = cool_q - 8'd1;
                    if (cool_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            angle_q     <= '0;
            power_q     <= '0;
            sin_mag_q   <= '0;
            cos_mag_q   <= '0;
            sin_neg_q   <= 1'b0;
            cos_neg_q   <= 1'b0;
            velx_q      <= '0;
            vely_q      <= '0;
            vel_valid_q <= 1'b0;
            angle_err_q <= 1'b0;
            cool_q      <= '0;
        end else begin
            state_q     <= state_d;
            angle_q     <= angle_d;
            power_q     <= power_d;
            sin_mag_q   <= sin_mag_d;
            cos_mag_q   <= cos_mag_d;
            sin_neg_q   <= sin_neg_d;
            cos_neg_q   <= cos_neg_d;
            velx_q      <= velx_d;
            vely_q      <= vely_d;
            vel_valid_q <= vel_valid_d;
            angle_err_q <= angle_err_d;
            cool_q      <= cool_d;
        end
    end

`ifdef CUE_LAUNCHER_SHOT_COUNT_EN
    logic [7:0] shot_count_q, shot_count_d;

    always_comb begin
        shot_count_d = handshake ? (shot_count_q + 8'd1) : shot_count_q;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            shot_count_q <= '0;
        end else begin
            shot_count_q <= shot_count_d;
        end
    end

    assign shot_count = shot_count_q;
`else
    assign shot_count = 8'd0;
`endif

    assign vel_valid = vel_valid_q;
    assign velX      = velx_q;
    assign velY      = vely_q;
    assign busy      = (state_q != ST_IDLE);
    assign angle_err = angle_err_q;

endmodule

// File: tb/tb_cue_launcher.sv
// tb/tb_cue_launcher.sv - randomized self-checking bench for cue_launcher against a trig reference model
module tb_cue_launcher;

    localparam int MIN_SPEED  = 16;
    localparam int SPEED_STEP = 4;
    localparam int POWER_MAX  = 100;
    localparam int VEL_W      = 11;
    localparam real PI        = 3.14159265358979;

    logic              clk = 1'b0;
    logic              resetN;
    logic              startOfFrame;
    logic              strike;
    logic [9:0]        angle;
    logic [7:0]        power;
    logic              vel_ready;
    logic              vel_valid;
    logic signed [VEL_W-1:0] velX;
    logic signed [VEL_W-1:0] velY;
    logic              busy;
    logic              angle_err;
    logic [7:0]        shot_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cue_launcher dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .strike       (strike),
        .angle        (angle),
        .power        (power),
        .vel_ready    (vel_ready),
        .vel_valid    (vel_valid),
        .velX         (velX),
        .velY         (velY),
        .busy         (busy),
        .angle_err    (angle_err),
        .shot_count   (shot_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int tbl(input int k);
        return $rtoi(256.0 * $sin(real'(k) * PI / 180.0) + 0.5);
    endfunction

    function automatic int fold(input int x);
        return (x <= 90) ? x : 180 - x;
    endfunction

    // X component is cos(a) = sin(a+90); both axes use the same sin rule on the shifted angle
    function automatic int exp_vel(input int a, input int p, input bit is_x);
        int pc, spd, ang, mag, v;
        pc  = (p > POWER_MAX) ? POWER_MAX : p;
        spd = MIN_SPEED + SPEED_STEP * pc;
        ang = is_x ? (a + 90) % 360 : a;
        mag = tbl(fold(ang % 180));
        v   = (spd * mag) / 256;
        return (ang >= 180) ? -v : v;
    endfunction

    function automatic int exp_shot();
`ifdef CUE_LAUNCHER_SHOT_COUNT_EN
        return exp_cnt % 256;
`else
        return 0;
`endif
    endfunction

    task automatic run_shot(input int a, input int p, input int hold, input bit poke);
        int ex, ey, lat;
        angle  = 10'(a);
        power  = 8'(p);
        strike = 1'b1;
        tick();
        strike = 1'b0;
        if (a > 359) begin
            check("err_pulse", angle_err, 1);
            check("err_busy", busy, 0);
            tick();
            check("err_one_cycle", angle_err, 0);
            tick();
            tick();
            check("err_no_valid", vel_valid, 0);
            check("err_idle", busy, 0);
            return;
        end
        ex  = exp_vel(a, p, 1'b1);
        ey  = exp_vel(a, p, 1'b0);
        lat = 1;
        while (!vel_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", lat, 3);
        check("velX", velX, ex);
        check("velY", velY, ey);
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 1) begin
                angle  = 10'($urandom_range(0, 359));
                power  = 8'($urandom_range(0, 255));
                strike = 1'b1;
            end
            tick();
            strike = 1'b0;
            check("hold_valid", vel_valid, 1);
            check("hold_velX", velX, ex);
            check("hold_velY", velY, ey);
            check("hold_no_err", angle_err, 0);
        end
        vel_ready = 1'b1;
        tick();
        vel_ready = 1'b0;
        exp_cnt++;
        check("hs_valid_low", vel_valid, 0);
        check("shot_count", shot_count, exp_shot());
        check("cool_busy", busy, 1);
        angle  = 10'd0;
        strike = 1'b1;
        tick();
        strike = 1'b0;
        check("cool_strike_drop", busy, 1);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("cool_after_sof1", busy, 1);
        strike = 1'b1;
        tick();
        strike = 1'b0;
        check("cool_strike2_drop", busy, 1);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("cool_done", busy, 0);
        check("cool_no_valid", vel_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        strike       = 1'b0;
        angle        = '0;
        power        = '0;
        vel_ready    = 1'b0;
        tick();
        tick();
        check("rst_valid", vel_valid, 0);
        check("rst_velX", velX, 0);
        check("rst_velY", velY, 0);
        check("rst_busy", busy, 0);
        check("rst_err", angle_err, 0);
        check("rst_count", shot_count, 0);
        resetN = 1'b1;
        tick();

        run_shot(0, 100, 0, 1'b0);
        run_shot(90, 0, 0, 1'b0);
        run_shot(225, 10, 5, 1'b1);
        run_shot(360, 50, 0, 1'b0);
        run_shot(359, 255, 2, 1'b1);
        run_shot(180, 100, 1, 1'b0);
        run_shot(270, 100, 0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            run_shot(int'($urandom_range(0, 419)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 4)), 1'b1);
        end

        angle  = 10'd45;
        power  = 8'd50;
        strike = 1'b1;
        tick();
        strike = 1'b0;
        tick();
        tick();
        check("pre_rst_valid", vel_valid, 1);
        resetN = 1'b0;
        tick();
        resetN  = 1'b1;
        exp_cnt = 0;
        check("mid_rst_valid", vel_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_velX", velX, 0);
        check("mid_rst_velY", velY, 0);
        check("mid_rst_count", shot_count, 0);
        tick();
        check("post_rst_idle", vel_valid, 0);

        run_shot(135, 77, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
